// File: rtl/fib_result_checker.sv
// fib_result_checker
//
// Snoops the data-memory store ports of the superscalar MIPS core. It checks
// that a run of Fibonacci terms is written, in address order, into a fixed
// word window. It ends with a sticky pass/fail verdict and captures the
// failing store.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-low
//   start      - one-cycle pulse: clear everything and enter RUN
//   st_we      - per-lane store strobe
//   st_addr    - per-lane word address, lane i at [i*ADDR_W +: ADDR_W]
//   st_data    - per-lane store data, lane i at [i*DATA_W +: DATA_W]
//   busy       - checker is in RUN
//   done       - verdict valid (sticky)
//   pass       - run passed (sticky, only with done)
//   fail_code  - 0 none, 1 data mismatch, 2 order, 3 timeout
//   term_count - number of terms accepted so far
//   err_addr   - address of the failing store
//   err_data   - value written by the failing store
//   exp_data   - value expected at the failure
//   cycles     - cycles spent in RUN
//
// Optional feature: define FIB_CHK_TRACE_EN to print every accepted term and
// the final verdict in simulation. It is never synthesised.

module fib_result_checker #(
  parameter int NUM_LANES      = 2,
  parameter int ADDR_W         = 8,
  parameter int DATA_W         = 32,
  parameter int START_IDX      = 2,
  parameter int NUM_TERMS      = 10,
  parameter int SEED0          = 0,
  parameter int SEED1          = 1,
  parameter int TIMEOUT_CYCLES = 300
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              start,
  input  logic [NUM_LANES-1:0]              st_we,
  input  logic [NUM_LANES*ADDR_W-1:0]       st_addr,
  input  logic [NUM_LANES*DATA_W-1:0]       st_data,
  output logic                              busy,
  output logic                              done,
  output logic                              pass,
  output logic [1:0]                        fail_code,
  output logic [$clog2(NUM_TERMS+1)-1:0]    term_count,
  output logic [ADDR_W-1:0]                 err_addr,
  output logic [DATA_W-1:0]                 err_data,
  output logic [DATA_W-1:0]                 exp_data,
  output logic [31:0]                       cycles
);

  localparam int TC_W = $clog2(NUM_TERMS + 1);
  localparam logic [31:0] WIN_LO = 32'(START_IDX);
  localparam logic [31:0] WIN_HI = 32'(START_IDX + NUM_TERMS);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   a_q, a_d, b_q, b_d;
  logic [TC_W-1:0]     term_count_q, term_count_d;
  logic [31:0]         cycles_q, cycles_d;
  logic [1:0]          fail_code_q, fail_code_d;
  logic [ADDR_W-1:0]   err_addr_q, err_addr_d;
  logic [DATA_W-1:0]   err_data_q, err_data_d;
  logic [DATA_W-1:0]   exp_data_q, exp_data_d;
  logic                done_q, done_d, pass_q, pass_d;

  // Per-cycle lane walk scratch
  logic [DATA_W-1:0]   run_a, run_b, nxt, lane_data;
  logic [31:0]         lane_addr, exp_addr, acc_cnt;
  logic [NUM_LANES-1:0] accept_vec;
  logic                stop, hit_fail, hit_pass;

  always_comb begin
    state_d      = state_q;
    a_d          = a_q;
    b_d          = b_q;
    term_count_d = term_count_q;
    cycles_d     = cycles_q;
    fail_code_d  = fail_code_q;
    err_addr_d   = err_addr_q;
    err_data_d   = err_data_q;
    exp_data_d   = exp_data_q;
    done_d       = done_q;
    pass_d       = pass_q;
    run_a        = a_q;
    run_b        = b_q;
    nxt          = '0;
    lane_data    = '0;
    lane_addr    = '0;
    exp_addr     = '0;
    acc_cnt      = '0;
    accept_vec   = '0;
    stop         = 1'b0;
    hit_fail     = 1'b0;
    hit_pass     = 1'b0;

    if (start) begin
      // start wins in every state, including a restart from RUN
      state_d      = S_RUN;
      a_d          = DATA_W'(SEED0);
      b_d          = DATA_W'(SEED1);
      term_count_d = '0;
      cycles_d     = '0;
      fail_code_d  = 2'd0;
      err_addr_d   = '0;
      err_data_d   = '0;
      exp_data_d   = '0;
      done_d       = 1'b0;
      pass_d       = 1'b0;
    end else if (state_q == S_RUN) begin
      cycles_d = cycles_q + 32'd1;
      // Lanes in ascending order. Each counted store consumes the next term of
      // the chained generator. The first failure or completion stops the walk.
      for (int i = 0; i < NUM_LANES; i++) begin
        lane_addr = 32'(st_addr[i*ADDR_W +: ADDR_W]);
        lane_data = st_data[i*DATA_W +: DATA_W];
        nxt       = run_a + run_b;
        exp_addr  = WIN_LO + 32'(term_count_q) + acc_cnt;
        if (!stop && st_we[i] && (lane_addr >= WIN_LO) && (lane_addr < WIN_HI)) begin
          if (lane_addr != exp_addr) begin
            hit_fail    = 1'b1;
            stop        = 1'b1;
            fail_code_d = 2'd2;
            err_addr_d  = st_addr[i*ADDR_W +: ADDR_W];
            err_data_d  = lane_data;
            exp_data_d  = nxt;
          end else if (lane_data != nxt) begin
            hit_fail    = 1'b1;
            stop        = 1'b1;
            fail_code_d = 2'd1;
            err_addr_d  = st_addr[i*ADDR_W +: ADDR_W];
            err_data_d  = lane_data;
            exp_data_d  = nxt;
          end else begin
            accept_vec[i] = 1'b1;
            acc_cnt       = acc_cnt + 32'd1;
            run_a         = run_b;
            run_b         = nxt;
            if (32'(term_count_q) + acc_cnt == 32'(NUM_TERMS)) begin
              hit_pass = 1'b1;
              stop     = 1'b1;
            end
          end
        end
      end

      // Terms accepted ahead of a failing lane in the same cycle still count
      term_count_d = term_count_q + TC_W'(acc_cnt);
      if (|accept_vec) begin
        a_d = run_a;
        b_d = run_b;
      end

      if (hit_fail) begin
        state_d = S_FAIL;
        done_d  = 1'b1;
      end else if (hit_pass) begin
        // A completing store beats a timeout landing on the same edge
        state_d = S_PASS;
        done_d  = 1'b1;
        pass_d  = 1'b1;
      end else if (cycles_d == 32'(TIMEOUT_CYCLES)) begin
        state_d     = S_FAIL;
        done_d      = 1'b1;
        fail_code_d = 2'd3;
        err_addr_d  = '0;
        err_data_d  = '0;
        exp_data_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      a_q          <= DATA_W'(SEED0);
      b_q          <= DATA_W'(SEED1);
      term_count_q <= '0;
      cycles_q     <= '0;
      fail_code_q  <= 2'd0;
      err_addr_q   <= '0;
      err_data_q   <= '0;
      exp_data_q   <= '0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      term_count_q <= term_count_d;
      cycles_q     <= cycles_d;
      fail_code_q  <= fail_code_d;
      err_addr_q   <= err_addr_d;
      err_data_q   <= err_data_d;
      exp_data_q   <= exp_data_d;
      done_q       <= done_d;
      pass_q       <= pass_d;
    end
  end

  assign busy       = (state_q == S_RUN);
  assign done       = done_q;
  assign pass       = pass_q;
  assign fail_code  = fail_code_q;
  assign term_count = term_count_q;
  assign err_addr   = err_addr_q;
  assign err_data   = err_data_q;
  assign exp_data   = exp_data_q;
  assign cycles     = cycles_q;

`ifdef FIB_CHK_TRACE_EN
  always @(posedge clk) begin
    if (reset && !start && state_q == S_RUN) begin
      for (int i = 0; i < NUM_LANES; i++) begin
        if (accept_vec[i]) begin
          $display("fib_result_checker: lane %0d addr %0d value %0d",
                   i, st_addr[i*ADDR_W +: ADDR_W], st_data[i*DATA_W +: DATA_W]);
        end
      end
      if (state_d == S_PASS) begin
        $display("fib_result_checker: PASS code %0d cycles %0d", fail_code_d, cycles_d);
      end else if (state_d == S_FAIL) begin
        $display("fib_result_checker: FAIL code %0d cycles %0d", fail_code_d, cycles_d);
      end
    end
  end
`else
  // Trace disabled: the checker logic is unchanged
`endif

endmodule

// File: doc/fib_result_checker.md
# fib_result_checker

Parametrised, self-checking store-stream monitor for the superscalar MIPS core. It snoops up to NUM_LANES data-memory store ports and checks that a run of Fibonacci terms is written in order to a fixed word window. Each term must match an internally generated sequence, and the run must finish within a cycle budget. It ends in a registered pass/fail verdict with error capture, replacing fixed-delay end-of-run memory dumps.

## Interface
- NUM_LANES, 2: number of store ports snooped (1..4)
- ADDR_W, 8: word-address width
- DATA_W, 32: term width; sequence arithmetic is modulo 2^DATA_W
- START_IDX, 2: word address of first checked term
- NUM_TERMS, 10: number of terms in the window (≥1)
- SEED0, 0 / SEED1, 1: the two terms preceding START_IDX
- TIMEOUT_CYCLES, 300: RUN cycles allowed before timeout
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low
- start  in  1  one-cycle pulse: clear and enter RUN
- st_we  in  NUM_LANES  per-lane store strobe
- st_addr  in  NUM_LANES*ADDR_W  lane i at [i*ADDR_W +: ADDR_W], word address
- st_data  in  NUM_LANES*DATA_W  lane i at [i*DATA_W +: DATA_W]
- busy  out  1  state is RUN
- done  out  1  sticky verdict-valid
- pass  out  1  sticky, only with done
- fail_code  out  2  0 none, 1 data mismatch, 2 order, 3 timeout
- term_count  out  $clog2(NUM_TERMS+1)  terms accepted
- err_addr  out  ADDR_W  address of failing store
- err_data  out  DATA_W  value written by failing store
- exp_data  out  DATA_W  value expected at failure
- cycles  out  32  cycles spent in RUN

## Operation
- States: IDLE, RUN, PASS, FAIL. Reset: IDLE; all outputs 0; generator a=SEED0, b=SEED1.
- IDLE/PASS/FAIL + start → RUN: clear counters, error registers, done, pass; reload seeds. start in RUN restarts identically.
- RUN, each cycle, lanes evaluated in ascending index. Only lanes with st_we=1 and START_IDX ≤ addr < START_IDX+NUM_TERMS count. Other stores are ignored.
- Counted store k in a cycle: expected address = START_IDX+term_count+k; expected value = k-th next term of (a,b).
  - Address differs → FAIL, code 2.
  - Address matches but data differs → FAIL, code 1.
  - Order is checked before data.
- First failing lane wins. Stores after it in that cycle are discarded. err_* capture that lane.
- Stores with no failure: term_count += number accepted; (a,b) advance that many steps via a chained adder of depth NUM_LANES.
- term_count reaching NUM_TERMS → PASS (done=1, pass=1). Later stores in the same cycle, and all later stores, are ignored.
- cycles increments every RUN cycle. If cycles reaches TIMEOUT_CYCLES without PASS → FAIL, code 3, err_* = 0. A completing store in that same cycle wins over timeout.
- Duplicate rewrite of an accepted address → FAIL code 2.

## Timing
- All outputs registered. A store sampled at edge n shows its verdict/term_count after edge n.
- start sampled at edge n: RUN from edge n; stores at edge n ignored.
- reset assertion mid-run: immediate return to IDLE, outputs 0, no verdict retained.
- Zero-latency pass-through of stores: snooping only, no backpressure.

## Configuration
- FIB_CHK_TRACE_EN defined: on each accepted term, `$display` prints lane, address, value. On verdict, prints PASS/FAIL, code and cycles. Not synthesised.
- Undefined: no display statements; logic identical otherwise.

## Test plan
- Defaults, lane 0 stores addr 2..11 with 1,2,3,5,8,13,21,34,55,89, one per cycle → done=1, pass=1, term_count=10, fail_code=0.
- Lanes 0,1 store (2,1),(3,2) same cycle, then (4,3),(5,5) … (10,55),(11,89) → pass after 5 store cycles, term_count=10.
- Store addr 4 value 3 as first term → FAIL code 2, err_addr=4, err_data=3, exp_data=1.
- Addr 2..5 correct, addr 6 value 9 → FAIL code 1, err_addr=6, err_data=9, exp_data=8, term_count=4.
- start, then no window stores for 300 cycles; store to addr 40 ignored → FAIL code 3 at cycles=300.
- Mid-run reset low after 4 terms, then start and full correct sequence → all outputs 0 during reset, then pass=1, term_count=10.
